pc_sequencer: RTL
=================

# pc_sequencer

Multicycle fetch/execute sequencer for the RV32I core's program counter. It computes `next_pc` for the PC register every cycle: it holds the PC during fetch and execute, then advances or redirects it when an instruction retires. It handshakes with instruction memory and the execute stage, and raises sticky halt/trap states on EBREAK/ECALL, misaligned targets or out-of-range targets.

## Interface
Parameters:
- `RESET_ADDR`, default 32'h0100_0000: boot address and base of instruction memory.
- `IMEM_WORDS`, default 1024: instruction memory size in 32-bit words. Legal fetch range is [RESET_ADDR, RESET_ADDR + 4*IMEM_WORDS).

Ports:
- `clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `current_pc`  in  32  PC register output.
- `next_pc`  out  32  PC register input; the register loads it every clock edge.
- `imem_req`  out  1  fetch request; address is `current_pc`.
- `imem_ack`  in  1  instruction data valid this cycle.
- `instr_valid`  out  1  one-cycle pulse: decode captures the instruction.
- `ex_done`  in  1  execute stage retires the current instruction.
- `br_taken`  in  1  redirect request, sampled with `ex_done`.
- `br_target`  in  32  redirect address, sampled with `ex_done`.
- `halt_req`  in  1  EBREAK/ECALL, sampled with `ex_done`.
- `halted`  out  1  sticky halt.
- `trap`  out  1  sticky fault.
- `trap_cause`  out  2  0 = none, 1 = misaligned, 2 = out of range.

## Operation
- FSM states: FETCH, EXEC, HALT, TRAP.
- During reset:
  - state goes to FETCH.
  - `next_pc` = RESET_ADDR (combinational while `reset` is high).
  - `imem_req`, `instr_valid`, `halted`, `trap` all = 0; `trap_cause` = 0.
- FETCH:
  - `imem_req` = 1; `next_pc` = `current_pc`.
  - On `imem_ack`: `instr_valid` = 1 in that cycle, then go to EXEC.
- EXEC:
  - `imem_req` = 0; `next_pc` = `current_pc` until `ex_done`.
  - On `ex_done`, target = `br_taken` ? `br_target` : `current_pc` + 4. The add is modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
  - Priority when several conditions hold: `halt_req` > misaligned > out of range > normal.
  - `halt_req`: go to HALT; PC held.
  - Target bits [1:0] != 0: go to TRAP, cause 1; PC held at the faulting instruction.
  - Target outside the legal range: go to TRAP, cause 2; PC held.
  - Otherwise: `next_pc` = target; go to FETCH.
- HALT/TRAP:
  - Terminal until reset.
  - `next_pc` = `current_pc`; `imem_req` = 0.
  - `halted`/`trap` = 1 and `trap_cause` stays stable.
- Ignored inputs: `imem_ack` outside FETCH, and `ex_done`/`br_*`/`halt_req` outside EXEC.
- Reset mid-operation, in any state: next cycle is FETCH at RESET_ADDR; sticky flags and counter cleared.

## Timing
- `next_pc`, `imem_req` and `instr_valid` are combinational from state and inputs; state and flags are registered.
- Zero-wait memory is allowed: `imem_ack` in the first FETCH cycle means FETCH lasts 1 cycle.
- Minimum instruction time is 2 cycles (FETCH 1 + EXEC 1).
- The PC changes at the clock edge that ends the `ex_done` cycle. The next FETCH presents the new PC one cycle later.
- `halted`/`trap` assert in the cycle after the sampling `ex_done`.
- Wait states are unbounded in both FETCH and EXEC; there is no timeout.

## Configuration
- Macro `PC_SEQ_RETIRE_CNT_EN`, when defined:
  - Adds output `instret` (out, 64), the retired-instruction counter.
  - Increments on each `ex_done` in EXEC that leads to FETCH or HALT. Trapping instructions do not count.
  - Resets to 0 and wraps at 2^64.
- When undefined, the port and counter are absent.

## Structure
- Package `pc_seq_pkg` holds:
  - `pc_seq_state_t` enum.
  - `trap_cause_t` enum (NONE, MISALIGN, RANGE).
  - `INSTR_BYTES` = 4.
- One sub-module, `pc_target_check`: combinational. Inputs are the target and the parameters; outputs are `misaligned` and `out_of_range`.

## Test plan
- Reset, then zero-wait `imem_ack` and `ex_done` with no branch, for 3 instructions:
  - `next_pc` sequence is 0100_0000 → 0100_0004 → 0100_0008.
  - `instr_valid` pulses once per instruction.
  - `instret` = 3 when enabled.
- `imem_ack` delayed 3 cycles and `ex_done` delayed 2 cycles → PC held throughout; `imem_req` is high for exactly 4 cycles.
- `br_taken` = 1 with `br_target` = 0100_0100 → next FETCH address is 0100_0100.
- `br_target` = 0100_0102 → `trap` = 1, `trap_cause` = 1, PC unchanged. Later `imem_ack`/`ex_done` are ignored.
- Target 0100_1000 with IMEM_WORDS = 1024 → `trap_cause` = 2. Same target with `halt_req` = 1 → `halted` = 1, `trap` = 0.
- Assert `reset` during a stalled EXEC after a prior trap:
  - Next cycle is FETCH at 0100_0000.
  - `trap` = 0, `trap_cause` = 0, `instret` = 0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2,
    ST_TRAP  = 2'd3
  } pc_seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_RANGE    = 2'd2
  } trap_cause_t;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/pc_target_check.sv
// Combinational legality check of a PC target: word alignment and imem range.
module pc_target_check
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0100_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic [31:0] target,
  output logic        misaligned,
  output logic        out_of_range
);

  localparam logic [31:0] ALIGN_MASK = 32'(INSTR_BYTES - 1);
  // 33-bit limit so a memory ending exactly at 2^32 does not wrap to zero
  localparam logic [32:0] LIMIT = {1'b0, RESET_ADDR} + 33'(IMEM_WORDS) * 33'(INSTR_BYTES);

  assign misaligned   = (target & ALIGN_MASK) != 32'd0;
  assign out_of_range = (target < RESET_ADDR) || ({1'b0, target} >= LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle fetch/execute sequencer producing next_pc, with sticky halt and trap.
// Define PC_SEQ_RETIRE_CNT_EN to add the 64-bit instret retired-instruction counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0100_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic [31:0] next_pc,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        halt_req,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
`ifdef PC_SEQ_RETIRE_CNT_EN
  output logic [63:0] instret,
`endif
  output logic [1:0]  dbg_state
);

  // Handshakes: imem_ack only counts while imem_req is high (FETCH); ex_done and
  // its companions br_*/halt_req only count in EXEC. Neither side is back-pressured.

  pc_seq_state_t state_q, state_d;
  trap_cause_t   cause_q, cause_d;
  logic          halted_q, halted_d;
  logic          trap_q, trap_d;
  logic [31:0]   target;
  logic          misaligned;
  logic          out_of_range;

  assign target = br_taken ? br_target : current_pc + 32'(INSTR_BYTES);

  pc_target_check #(
    .RESET_ADDR (RESET_ADDR),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_target_check (
    .target       (target),
    .misaligned   (misaligned),
    .out_of_range (out_of_range)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    halted_d    = halted_q;
    trap_d      = trap_q;
    next_pc     = current_pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_valid = 1'b1;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          if (halt_req) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (misaligned) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else if (out_of_range) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = CAUSE_RANGE;
          end else begin
            next_pc = target;
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    if (reset) begin
      next_pc     = RESET_ADDR;
      imem_req    = 1'b0;
      instr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      cause_q  <= CAUSE_NONE;
      halted_q <= 1'b0;
      trap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      halted_q <= halted_d;
      trap_q   <= trap_d;
    end
  end

  assign halted     = halted_q;
  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign dbg_state  = state_q;

`ifdef PC_SEQ_RETIRE_CNT_EN
  logic        retire;
  logic [63:0] instret_q, instret_d;

  // Halting instructions retire; trapping ones do not.
  assign retire = (state_q == ST_EXEC) && ex_done &&
                  (halt_req || !(misaligned || out_of_range));

  always_comb begin
    instret_d = instret_q + 64'(retire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= 64'd0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`endif

endmodule
